// File: rtl/online_b2c_converter.sv
// online_b2c_converter: MSD-first conversion of a borrow-save word to two's complement.
// Each digit is {d_plus, d_minus} with value d_plus - d_minus; digit N-1 arrives first.
// Conversion keeps two candidate results, Q and QM = Q - 1, so no carry ever ripples.
// Optional feature macro: ONLINE_B2C_ABS_EN adds an ABS state that returns the magnitude
// in out_data and the sign in out_neg, at the cost of one extra cycle.
module online_b2c_converter #(
    parameter int Stage = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   enable,
    input  logic [2*(Stage+4)-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [Stage+4:0]       out_data,
    output logic                   out_neg,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int N  = Stage + 4;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Q needs its sign bit stored only when ABS inspects it a cycle after the last digit;
    // otherwise the final sign is taken straight from the next-value logic.
`ifdef ONLINE_B2C_ABS_EN
    localparam int QW = N + 1;
    localparam logic [N:0] ONE = (N+1)'(1);
`else
    localparam int QW = N;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        ABS  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [2*N-1:0]  word;
    logic [QW-1:0]   q;
    logic [N-1:0]    qm;
    logic [CW-1:0]   cnt;
    logic            dp;
    logic            dm;
    logic [N:0]      q_next;
    logic [N-1:0]    qm_next;

    // The word register shifts left, so the digit being consumed always sits at the top.
    assign dp       = word[2*N-1];
    assign dm       = word[2*N-2];
    assign in_ready = (state == IDLE);

    // On-the-fly conversion step: append the digit to whichever candidate stays exact.
    always_comb begin
        q_next  = {q[N-1:0], 1'b0};
        qm_next = {qm[N-2:0], 1'b1};
        if (dp && !dm) begin
            q_next  = {q[N-1:0], 1'b1};
            qm_next = {q[N-2:0], 1'b0};
        end else if (!dp && dm) begin
            q_next  = {qm, 1'b1};
            qm_next = {qm[N-2:0], 1'b0};
        end
    end

    // Control FSM with registered result; disable behaves like a synchronous reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            word      <= '0;
            q         <= '0;
            qm        <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_neg   <= 1'b0;
            out_valid <= 1'b0;
        end else if (!enable) begin
            state     <= IDLE;
            word      <= '0;
            q         <= '0;
            qm        <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_neg   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word  <= in_data;
                        q     <= '0;
                        qm    <= '1;
                        cnt   <= CNT_TOP;
                        state <= CONV;
                    end
                end
                CONV: begin
                    q    <= q_next[QW-1:0];
                    qm   <= qm_next;
                    word <= {word[2*N-3:0], 2'b00};
                    if (cnt == '0) begin
`ifdef ONLINE_B2C_ABS_EN
                        state <= ABS;
`else
                        out_data  <= q_next;
                        out_neg   <= q_next[N];
                        out_valid <= 1'b1;
                        state     <= DONE;
`endif
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
`ifdef ONLINE_B2C_ABS_EN
                ABS: begin
                    out_neg   <= q[N];
                    out_data  <= q[N] ? (~q + ONE) : q;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_online_b2c_converter.sv
// Bench for online_b2c_converter at Stage=8 (24-bit redundant in, 13-bit result out).
module tb_online_b2c_converter;
    localparam int N = 12;
`ifdef ONLINE_B2C_ABS_EN
    localparam int LAT = N + 1;
`else
    localparam int LAT = N;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        enable;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] out_data;
    logic        out_neg;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    online_b2c_converter #(.Stage(8)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .enable    (enable),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_neg   (out_neg),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] din;
        logic [12:0] data;
        logic        neg;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word value is the plain weighted sum of signed digits.
    function automatic int model_val(input logic [23:0] w);
        int v = 0;
        for (int i = 0; i < N; i++)
            v += (int'(w[2*i+1]) - int'(w[2*i])) * (1 << i);
        return v;
    endfunction

    function automatic logic [12:0] model_data(input logic [23:0] w);
        int v = model_val(w);
`ifdef ONLINE_B2C_ABS_EN
        if (v < 0) v = -v;
`endif
        return 13'(v);
    endfunction

    // Table entries hold two's-complement results; the magnitude build negates them.
    function automatic logic [12:0] build_data(input logic [12:0] d, input logic neg);
`ifdef ONLINE_B2C_ABS_EN
        return neg ? 13'(0 - d) : d;
`else
        return d;
`endif
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 back in IDLE.
    task automatic run_word(input logic [23:0] w, input logic [12:0] ed, input logic en,
                            input string nm);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check({nm, " accepted"}, {31'd0, in_ready}, 32'd0);
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check({nm, " latency"}, n, LAT);
        check({nm, " data"}, {19'd0, out_data}, {19'd0, ed});
        check({nm, " neg"}, {31'd0, out_neg}, {31'd0, en});
        @(posedge clk);
        #1;
        check({nm, " back_idle"}, {31'd0, in_ready}, 32'd1);
        check({nm, " valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [23:0] w;
        int n;

        vecs[0] = '{24'h000000, 13'h0000, 1'b0, "zero"};
        vecs[1] = '{24'hFFFFFF, 13'h0000, 1'b0, "all11"};
        vecs[2] = '{24'h800000, 13'h0800, 1'b0, "msd_pos"};
        vecs[3] = '{24'h000001, 13'h1FFF, 1'b1, "lsd_neg"};
        vecs[4] = '{24'h800001, 13'h07FF, 1'b0, "mixed"};
        vecs[5] = '{24'h555555, 13'h1001, 1'b1, "all_neg"};
        vecs[6] = '{24'hAAAAAA, 13'h0FFF, 1'b0, "all_pos"};

        nrst      = 1'b0;
        enable    = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst out_data", {19'd0, out_data}, 32'd0);
        check("rst out_neg", {31'd0, out_neg}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++)
            run_word(vecs[i].din, build_data(vecs[i].data, vecs[i].neg), vecs[i].neg,
                     vecs[i].name);

        // Backpressure: result held, new words ignored while DONE waits on out_ready.
        out_ready = 1'b0;
        in_data   = 24'h800001;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("bp latency", n, LAT);
        for (int k = 0; k < 5; k++) begin
            check("bp data", {19'd0, out_data}, 32'h07FF);
            check("bp valid", {31'd0, out_valid}, 32'd1);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
            in_data  = 24'(k * 24'h111111 + 24'h5A5A5A);
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
        check("bp data end", {19'd0, out_data}, 32'h07FF);
        check("bp neg end", {31'd0, out_neg}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release idle", {31'd0, in_ready}, 32'd1);
        check("bp release valid", {31'd0, out_valid}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp no queue", {31'd0, in_ready}, 32'd1);
        end

        // Asynchronous reset in the middle of a conversion.
        run_word(24'h000001, build_data(13'h1FFF, 1'b1), 1'b1, "pre_rst");
        in_data  = 24'h555555;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        check("arst out_data", {19'd0, out_data}, 32'd0);
        check("arst out_neg", {31'd0, out_neg}, 32'd0);
        check("arst out_valid", {31'd0, out_valid}, 32'd0);
        check("arst in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        run_word(24'h800000, 13'h0800, 1'b0, "after_rst");

        // Synchronous disable for one edge in the middle of a conversion.
        in_data  = 24'h555555;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        #1;
        check("dis out_data", {19'd0, out_data}, 32'd0);
        check("dis out_valid", {31'd0, out_valid}, 32'd0);
        check("dis in_ready", {31'd0, in_ready}, 32'd1);
        enable = 1'b1;
        run_word(24'h800000, 13'h0800, 1'b0, "after_dis");

        // Random back-to-back words against the arithmetic model.
        for (int k = 0; k < 24; k++) begin
            w = 24'($urandom);
            run_word(w, model_data(w), model_val(w) < 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/online_b2c_converter.md
# online_b2c_converter

Result-side companion to the online Sobel datapath. It accepts one redundant borrow-save result word of the kind `online_sobel` produces on `data_out`, and converts it most-significant-digit first. Conversion uses on-the-fly conversion with two registers, Q and QM, and processes one digit per clock. The output is a conventional two's-complement integer, returned over a valid/ready handshake. The block sits between the Sobel core and the test platform's result capture and readback logic.

## Interface
- `Stage`, default 8: matches the Sobel core parameter. Derived values:
  - N = Stage+4 digits.
  - Input width 2N (24 bits at default).
  - Output width N+1 (13 bits at default).
- `clk`  in  1: single clock, rising edge.
- `nrst`  in  1: reset, asynchronous and active-low.
- `enable`  in  1: synchronous run enable. 0 forces a return to IDLE and clears all state.
- `in_data`  in  2N: redundant word.
  - Digit i occupies bits [2i+1:2i] = {d_plus, d_minus}.
  - Digit value = d_plus − d_minus, so each digit is −1, 0 or +1.
  - Code 2'b11 is a legal encoding of 0.
  - Digit N−1 is the most significant.
  - Word value = Σ d_i·2^i.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the converter can accept a word.
- `out_data`  out  N+1: result (see Configuration for its encoding).
- `out_neg`  out  1: the converted value is negative.
- `out_valid`  out  1: `out_data` and `out_neg` are valid.
- `out_ready`  in  1: the sink accepts the result.

## Operation
- States: IDLE, CONV, ABS (only with the macro), DONE.
- Reset and disable behaviour (async `nrst`=0, or `enable`=0 at a clock edge):
  - state goes to IDLE;
  - the word register, Q, QM and the digit counter all go to 0;
  - `out_data`=0, `out_neg`=0, `out_valid`=0.
  - This applies from any state, mid-conversion included; the partial result is discarded.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`:
    - latch `in_data`;
    - Q←0, QM←all ones (−1);
    - cnt←N−1;
    - go to CONV.
- CONV: consume digit d = digit[cnt], with all shifts within N+1 bits:
  - d=+1: Q←2Q+1, QM←2Q.
  - d=0: Q←2Q, QM←2QM+1.
  - d=−1: Q←2QM+1, QM←2QM.
  - If cnt==0: leave CONV. Go to ABS if the macro is defined, else to DONE.
  - Otherwise cnt←cnt−1.
- ABS (macro only):
  - `out_neg`←Q[N].
  - `out_data`←(Q[N] ? −Q : Q).
  - Go to DONE.
- DONE:
  - `out_valid`=1; `out_data` and `out_neg` are held stable.
  - On `out_valid`&&`out_ready`: go to IDLE.
- `in_ready`=1 only in IDLE. `in_valid` in any other state is ignored, not queued.
- Range: |value| ≤ 2^N−1, which always fits in N+1 bits signed. No overflow is possible, so there is no error flag.

## Timing
- Let the accept edge be edge 0.
  - Without the macro, `out_valid` rises at edge N (12 at default).
  - With the macro, it rises at edge N+1.
- Earliest next accept: the edge after IDLE is re-entered.
  - Minimum period without the macro is N+2 cycles per word when `out_ready`=1.
- `out_ready` held low: the block stays in DONE indefinitely and outputs do not change.
- Outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `ONLINE_B2C_ABS_EN`
  - Defined:
    - adds the ABS state and one cycle of latency;
    - `out_data` is the magnitude |value| (zero-extended, N+1 bits);
    - `out_neg` is the sign.
  - Undefined:
    - no ABS state;
    - `out_data` is the two's-complement value;
    - `out_neg` = `out_data`[N], set at the CONV→DONE transition.

## Test plan
Default Stage=8; the macro is undefined unless stated.
- All-zero and digit-11 words:
  - `in_data`=24'h000000 → `out_data`=13'h0000, `out_neg`=0, `out_valid` at edge 12.
  - `in_data`=24'hFFFFFF (all digits 11) → 13'h0000.
- Single-digit words:
  - MSD +1 only, `in_data`=24'h800000 → 13'h0800 (2048).
  - LSD −1 only, `in_data`=24'h000001 → 13'h1FFF (−1), `out_neg`=1.
- Mixed digits and extremes:
  - 24'h800001 → 13'h07FF (2047).
  - 24'h555555 (all −1) → 13'h1001 (−4095).
  - 24'hAAAAAA (all +1) → 13'h0FFF.
  - With `ONLINE_B2C_ABS_EN`: 24'h555555 → `out_data`=13'h0FFF, `out_neg`=1, valid at edge 13.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles after `out_valid`: data stays stable, `in_ready`=0, and `in_valid` pulses are ignored.
  - Then `out_ready`=1: IDLE on the next edge, with `in_ready`=1.
- Reset and disable mid-conversion:
  - Assert `nrst`=0 asynchronously at cycle 5 of CONV: all outputs are 0 immediately.
  - After release, a new word 24'h800000 converts to 13'h0800.
  - Repeat using `enable`=0 for one edge: same recovery.
- Back-to-back words with `out_ready` tied high (random words vs. reference model):
  - results match in order;
  - accepts are spaced exactly 14 cycles apart.
